// File: rtl/image_write.sv
// image_write: captures two pixels per clock into a frame buffer stored in BMP
// bottom-up row order, and offers a registered one-pixel-per-address readback.
module image_write #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          frame_start,
  input  logic          HSYNC,
  input  logic [7:0]    DATA_R0,
  input  logic [7:0]    DATA_G0,
  input  logic [7:0]    DATA_B0,
  input  logic [7:0]    DATA_R1,
  input  logic [7:0]    DATA_G1,
  input  logic [7:0]    DATA_B1,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data,
  output logic          write_done,
  output logic          busy,
  output logic          overflow,
  output logic [AW-1:0] pair_count
);
  localparam int HALF   = WIDTH / 2;
  localparam int NWORDS = HALF * HEIGHT;
  localparam int CW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WAW    = AW - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [CW-1:0]  col_pair_r;
  logic [RW-1:0]  row_r;
  logic [AW-1:0]  pair_count_r;
  logic           write_done_r;
  logic           busy_r;
  logic           overflow_r;
  logic [23:0]    rd_data_r;
  logic           accept_s;
  logic           last_col_s;
  logic           last_row_s;
  logic [WAW-1:0] wr_word_s;
  logic [47:0]    wr_data_s;
  logic [47:0]    rd_word_s;
  logic [47:0]    mem_r [NWORDS];

  assign last_col_s = (col_pair_r == CW'(HALF - 1));
  assign last_row_s = (row_r == RW'(HEIGHT - 1));

  // Next-state and accept decode; frame_start overrides everything, dropping a coincident pair.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    if (frame_start) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_RECV: begin
          if (HSYNC) begin
            accept_s = 1'b1;
            state_s  = (last_col_s && last_row_s) ? ST_DONE : ST_RECV;
          end else begin
            state_s = state_r;
          end
        end
        ST_DONE: state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Write word address flips the row so the first line lands in the bottom BMP row.
  always_comb begin
    wr_word_s = WAW'((HEIGHT - 1 - int'(row_r)) * HALF + int'(col_pair_r));
    wr_data_s = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
    rd_word_s = mem_r[rd_addr[AW-1:1]];
  end

  // Frame buffer storage; contents survive reset and frame_start.
  always_ff @(posedge HCLK) begin
    if (accept_s && HRESET) begin
      mem_r[wr_word_s] <= wr_data_s;
    end
  end

  // State, counters, status flags and registered readback.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_r      <= ST_IDLE;
      col_pair_r   <= '0;
      row_r        <= '0;
      pair_count_r <= '0;
      write_done_r <= 1'b0;
      busy_r       <= 1'b0;
      overflow_r   <= 1'b0;
      rd_data_r    <= 24'd0;
    end else begin
      state_r      <= state_s;
      busy_r       <= (state_s == ST_RECV);
      write_done_r <= (state_s == ST_DONE);
      rd_data_r    <= rd_addr[0] ? rd_word_s[47:24] : rd_word_s[23:0];
      if (frame_start) begin
        col_pair_r   <= '0;
        row_r        <= '0;
        pair_count_r <= '0;
        overflow_r   <= 1'b0;
      end else begin
        if (accept_s) begin
          if (last_col_s) begin
            col_pair_r <= '0;
            row_r      <= last_row_s ? '0 : row_r + 1'b1;
          end else begin
            col_pair_r <= col_pair_r + 1'b1;
          end
          if (pair_count_r != AW'(NWORDS)) begin
            pair_count_r <= pair_count_r + 1'b1;
          end
        end
        if ((state_r == ST_DONE) && HSYNC) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  assign rd_data    = rd_data_r;
  assign write_done = write_done_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign pair_count = pair_count_r;

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write: a 4x2 instance for the scenarios and a
// 768-pixel-wide instance for the column ramp.
`timescale 1ns/1ps
module tb_image_write;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int AW  = 3;
  localparam int WW  = 768;
  localparam int WH  = 4;
  localparam int WAW = $clog2(WW*WH);

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic hreset, frame_start, hsync;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [AW-1:0] rd_addr, pair_count;
  logic [23:0] rd_data;
  logic write_done, busy, overflow;

  logic w_frame_start, w_hsync;
  logic [7:0] w_r0, w_g0, w_b0, w_r1, w_g1, w_b1;
  logic [WAW-1:0] w_rd_addr, w_pair_count;
  logic [23:0] w_rd_data;
  logic w_write_done, w_busy, w_overflow;

  int tests = 0;
  int fails = 0;

  image_write #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .HCLK(hclk), .HRESET(hreset), .frame_start(frame_start), .HSYNC(hsync),
    .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
    .rd_addr(rd_addr), .rd_data(rd_data), .write_done(write_done), .busy(busy),
    .overflow(overflow), .pair_count(pair_count)
  );

  image_write #(.WIDTH(WW), .HEIGHT(WH), .AW(WAW)) dut_wide (
    .HCLK(hclk), .HRESET(hreset), .frame_start(w_frame_start), .HSYNC(w_hsync),
    .DATA_R0(w_r0), .DATA_G0(w_g0), .DATA_B0(w_b0), .DATA_R1(w_r1), .DATA_G1(w_g1), .DATA_B1(w_b1),
    .rd_addr(w_rd_addr), .rd_data(w_rd_data), .write_done(w_write_done), .busy(w_busy),
    .overflow(w_overflow), .pair_count(w_pair_count)
  );

  function automatic logic [23:0] pix(input logic [7:0] r);
    return {r, r ^ 8'h55, ~r};
  endfunction

  // Expected R of readback pixel p in the 4x2 buffer: addr 0..3 hold the last line.
  function automatic logic [7:0] exp_r(input int p, input logic [7:0] base0, input logic [7:0] base1);
    logic [7:0] col;
    col = 8'(p % 4);
    return (p < 4) ? base1 + col : base0 + col;
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_pair(input logic [7:0] ra);
    hsync = 1'b1;
    r0 = ra;          g0 = ra ^ 8'h55;          b0 = ~ra;
    r1 = ra + 8'd1;   g1 = (ra + 8'd1) ^ 8'h55; b1 = ~(ra + 8'd1);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    hreset = 1'b0;
    tick();
    tick();
    tests++;
    if ({write_done, busy, overflow, pair_count, rd_data} !== 30'd0) begin
      fails++;
      $display("FAIL reset: got wd=%b busy=%b ovf=%b pc=%0d rd=%h, expected all zero",
               write_done, busy, overflow, pair_count, rd_data);
    end
    hreset = 1'b1;
    tick();
  endtask

  task automatic test_full_frame(input logic [7:0] base0, input logic [7:0] base1, input int gap);
    logic [7:0] ra;
    pulse_frame_start();
    for (int n = 0; n < 4; n++) begin
      ra = ((n / 2) == 1 ? base1 : base0) + 8'(2 * (n % 2));
      set_pair(ra);
      tick();
      hsync = 1'b0;
      tests++;
      if (pair_count !== 3'(n + 1) || write_done !== (n == 3) || busy !== (n != 3)) begin
        fails++;
        $display("FAIL accept%0d gap%0d: got pc=%0d wd=%b busy=%b, expected pc=%0d wd=%b busy=%b",
                 n, gap, pair_count, write_done, busy, n + 1, (n == 3), (n != 3));
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        tests++;
        if (pair_count !== 3'(n + 1) || write_done !== (n == 3)) begin
          fails++;
          $display("FAIL gap idle after accept%0d: got pc=%0d wd=%b, expected pc=%0d wd=%b",
                   n, pair_count, write_done, n + 1, (n == 3));
        end
      end
    end
    for (int p = 0; p < 8; p++) begin
      rd_addr = 3'(p);
      tick();
      tests++;
      if (rd_data !== pix(exp_r(p, base0, base1))) begin
        fails++;
        $display("FAIL readback gap%0d addr%0d: got %h expected %h", gap, p, rd_data, pix(exp_r(p, base0, base1)));
      end
    end
  endtask

  task automatic test_overflow();
    set_pair(8'hEE);
    tick();
    tick();
    hsync = 1'b0;
    tick();
    tests++;
    if (overflow !== 1'b1 || pair_count !== 3'd4 || write_done !== 1'b1) begin
      fails++;
      $display("FAIL overflow flags: got ovf=%b pc=%0d wd=%b, expected ovf=1 pc=4 wd=1", overflow, pair_count, write_done);
    end
    for (int p = 0; p < 8; p += 7) begin
      rd_addr = 3'(p);
      tick();
      tests++;
      if (rd_data !== pix(exp_r(p, 8'h50, 8'h60))) begin
        fails++;
        $display("FAIL overflow buffer addr%0d: got %h expected %h", p, rd_data, pix(exp_r(p, 8'h50, 8'h60)));
      end
    end
  endtask

  task automatic test_frame_start_collision();
    pulse_frame_start();
    tests++;
    if (overflow !== 1'b0 || write_done !== 1'b0 || pair_count !== 3'd0) begin
      fails++;
      $display("FAIL frame_start clear: got ovf=%b wd=%b pc=%0d, expected 0 0 0", overflow, write_done, pair_count);
    end
    set_pair(8'h70); tick();
    set_pair(8'h72); tick();
    hsync = 1'b0;
    tests++;
    if (pair_count !== 3'd2 || busy !== 1'b1) begin
      fails++;
      $display("FAIL two pairs: got pc=%0d busy=%b, expected pc=2 busy=1", pair_count, busy);
    end
    frame_start = 1'b1;
    set_pair(8'hAA);
    tick();
    frame_start = 1'b0;
    hsync = 1'b0;
    tests++;
    if (pair_count !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL collision counters: got pc=%0d busy=%b, expected pc=0 busy=0", pair_count, busy);
    end
    rd_addr = 3'd0;
    tick();
    tests++;
    if (rd_data !== pix(8'h60)) begin
      fails++;
      $display("FAIL collision dropped pair: got %h expected %h", rd_data, pix(8'h60));
    end
    test_full_frame(8'h80, 8'h90, 0);
  endtask

  task automatic test_async_reset();
    pulse_frame_start();
    set_pair(8'hC0); tick();
    set_pair(8'hC2); tick();
    hsync = 1'b0;
    #3;
    hreset = 1'b0;
    #1;
    tests++;
    if ({write_done, busy, overflow, pair_count, rd_data} !== 30'd0) begin
      fails++;
      $display("FAIL async reset: got wd=%b busy=%b ovf=%b pc=%0d rd=%h, expected all zero",
               write_done, busy, overflow, pair_count, rd_data);
    end
    tick();
    hreset = 1'b1;
    set_pair(8'hC8);
    tick();
    hsync = 1'b0;
    tests++;
    if (pair_count !== 3'd1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL recapture counters: got pc=%0d busy=%b, expected pc=1 busy=1", pair_count, busy);
    end
    for (int p = 4; p < 6; p++) begin
      rd_addr = 3'(p);
      tick();
      tests++;
      if (rd_data !== pix(8'hC8 + 8'(p - 4))) begin
        fails++;
        $display("FAIL recapture row0 addr%0d: got %h expected %h", p, rd_data, pix(8'hC8 + 8'(p - 4)));
      end
    end
  endtask

  task automatic test_wide_ramp();
    int n;
    int addrs [5];
    logic [23:0] exps [5];
    n = 0;
    w_frame_start = 1'b1;
    tick();
    w_frame_start = 1'b0;
    for (int line = 0; line < WH; line++) begin
      for (int k = 0; k < WW / 2; k++) begin
        w_hsync = 1'b1;
        w_r0 = 8'(2 * k);     w_g0 = 8'(line); w_b0 = 8'hB0;
        w_r1 = 8'(2 * k + 1); w_g1 = 8'(line); w_b1 = 8'hB0;
        tick();
        n++;
        if (n == WW / 2 * WH - 1) begin
          tests++;
          if (w_write_done !== 1'b0) begin
            fails++;
            $display("FAIL wide early done: got wd=%b at accept %0d, expected 0", w_write_done, n);
          end
        end
      end
    end
    w_hsync = 1'b0;
    tests++;
    if (w_write_done !== 1'b1 || w_pair_count !== 12'd1536) begin
      fails++;
      $display("FAIL wide done: got wd=%b pc=%0d, expected wd=1 pc=1536", w_write_done, w_pair_count);
    end
    addrs = '{0, 300, 767, 2304, 3071};
    exps  = '{24'h0003B0, 24'h2C03B0, 24'hFF03B0, 24'h0000B0, 24'hFF00B0};
    for (int i = 0; i < 5; i++) begin
      w_rd_addr = WAW'(addrs[i]);
      tick();
      tests++;
      if (w_rd_data !== exps[i]) begin
        fails++;
        $display("FAIL wide readback addr%0d: got %h expected %h", addrs[i], w_rd_data, exps[i]);
      end
    end
  endtask

  initial begin
    hreset = 1'b0; frame_start = 1'b0; hsync = 1'b0;
    r0 = 8'd0; g0 = 8'd0; b0 = 8'd0; r1 = 8'd0; g1 = 8'd0; b1 = 8'd0;
    rd_addr = '0;
    w_frame_start = 1'b0; w_hsync = 1'b0;
    w_r0 = 8'd0; w_g0 = 8'd0; w_b0 = 8'd0; w_r1 = 8'd0; w_g1 = 8'd0; w_b1 = 8'd0;
    w_rd_addr = '0;
    test_reset();
    test_full_frame(8'h10, 8'h20, 0);
    test_full_frame(8'h50, 8'h60, 3);
    test_overflow();
    test_frame_start_collision();
    test_async_reset();
    test_wide_ramp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
